// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, FSM states and
// the helper that decides which opcodes report overflow.
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    function automatic logic op_has_of(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational 32-bit ALU shared by the arbiter. OF carries the
// raw add/sub overflow; callers mask it for non-arithmetic ops.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] OUT,
    output logic        ZERO,
    output logic        OF
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic        oflow_add;
    logic        oflow_sub;

    assign sum       = A + B;
    assign diff      = A - B;
    assign oflow_add = (A[31] == B[31]) && (sum[31] != A[31]);
    assign oflow_sub = (A[31] != B[31]) && (diff[31] != A[31]);

    // SLT uses the corrected sign of A-B so it stays right across overflow.
    always_comb begin
        OUT = '0;
        case (OP)
            ALU_AND: OUT = A & B;
            ALU_OR:  OUT = A | B;
            ALU_ADD: OUT = sum;
            ALU_SUB: OUT = diff;
            ALU_SLT: OUT = {31'd0, diff[31] ^ oflow_sub};
            ALU_NOT: OUT = ~A;
            ALU_NOR: OUT = ~(A | B);
            ALU_XOR: OUT = A ^ B;
            default: OUT = '0;
        endcase
    end

    assign ZERO = (OUT == 32'd0);
    assign OF   = (OP == ALU_SUB) ? oflow_sub : oflow_add;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request after
// last_grant (wrapping) wins; outputs the one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Walk from lowest to highest priority so the nearest requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[wrap_idx(last_grant, k)]) begin
                grant_idx = wrap_idx(last_grant, k);
                grant     = NREQ'(1) << wrap_idx(last_grant, k);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant, one-cycle execute,
// and a registered result held until the winning requester accepts it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0] rsp_valid,
    input  logic [NREQ-1:0] rsp_ready,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_zero,
    output logic            rsp_of
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state;
    logic [IW-1:0]   last_grant;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [2:0]      sel_op;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W-1:0]    alu_out;
    logic            alu_zero;
    logic            alu_of;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[W*i +: W];
                sel_b  = req_b[W*i +: W];
            end
        end
    end

    assign req_ready = (state == ARB_IDLE) ? grant : '0;

    alu u_alu (
        .OP   (op_q),
        .A    (a_q),
        .B    (b_q),
        .OUT  (alu_out),
        .ZERO (alu_zero),
        .OF   (alu_of)
    );

    // last_grant doubles as the index of the in-flight winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= IW'(NREQ - 1);
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_of     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|grant) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        last_grant <= grant_idx;
                        state      <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_zero  <= alu_zero;
                    rsp_of    <= alu_of & op_has_of(op_q);
                    rsp_valid <= NREQ'(1) << last_grant;
                    state     <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (rsp_ready[last_grant]) begin
                        rsp_valid <= '0;
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-requester operations plus
// hand-written round-robin, backpressure and mid-transaction reset sequences.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_zero;
    logic              rsp_of;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          req;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_of;
    } vec_t;

    vec_t vecs[12];

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_of    (rsp_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_operands(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*r +: 3] = op;
        req_a[W*r +: W]  = a;
        req_b[W*r +: W]  = b;
    endtask

    // One full transaction for requester v.req, checking every phase.
    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [NREQ-1:0] onehot;
        onehot = NREQ'(1) << v.req;
        @(negedge clk);
        load_operands(v.req, v.op, v.a, v.b);
        req_valid = onehot;
        #1 check($sformatf("vec%0d grant", idx), 32'(req_ready), 32'(onehot));
        @(negedge clk);
        req_valid = '0;
        #1 check($sformatf("vec%0d exec ready", idx), 32'(req_ready), 32'd0);
        check($sformatf("vec%0d exec rsp_valid", idx), 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_output(v, idx, onehot);
        rsp_ready = onehot;
        @(negedge clk);
        rsp_ready = '0;
        check($sformatf("vec%0d released", idx), 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_output(input vec_t v, input int idx, input logic [NREQ-1:0] onehot);
        check($sformatf("vec%0d rsp_valid", idx), 32'(rsp_valid), 32'(onehot));
        check($sformatf("vec%0d rsp_data", idx), rsp_data, v.exp_data);
        check($sformatf("vec%0d rsp_zero", idx), 32'(rsp_zero), 32'(v.exp_zero));
        check($sformatf("vec%0d rsp_of", idx), 32'(rsp_of), 32'(v.exp_of));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_g;

        vecs[0]  = '{1, 3'b010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
        vecs[1]  = '{0, 3'b010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1};
        vecs[2]  = '{2, 3'b011, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[3]  = '{3, 3'b001, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{0, 3'b100, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[5]  = '{1, 3'b100, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0};
        vecs[6]  = '{2, 3'b111, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0};
        vecs[7]  = '{3, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[8]  = '{0, 3'b101, 32'd0,        32'd5,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{1, 3'b110, 32'h0F0F0000, 32'h00F0000F, 32'hF000FFF0, 1'b0, 1'b0};
        vecs[10] = '{2, 3'b011, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[11] = '{3, 3'b001, 32'h80000000, 32'd1,        32'h80000001, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        #2;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset rsp_zero", 32'(rsp_zero), 32'd0);
        check("reset rsp_of", 32'(rsp_of), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Round-robin: everyone requesting, responses accepted at once.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) load_operands(i, 3'b010, 32'(i + 10), 32'(i));
        req_valid = '1;
        rsp_ready = '1;
        for (int g = 0; g < 5; g++) begin
            exp_g = g % NREQ;
            #1 check($sformatf("rr grant %0d", g), 32'(req_ready), 32'd1 << exp_g);
            @(negedge clk);
            #1 check($sformatf("rr exec ready %0d", g), 32'(req_ready), 32'd0);
            @(negedge clk);
            check($sformatf("rr rsp_valid %0d", g), 32'(rsp_valid), 32'd1 << exp_g);
            check($sformatf("rr rsp_data %0d", g), rsp_data, 32'(2 * exp_g + 10));
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '0;

        // Backpressure: last grant was 0, so requester 2 wins over 0 and 3.
        req_valid = 4'b1101;
        #1 check("bp grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b1001;
        @(negedge clk);
        rsp_ready = 4'b1011;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp rsp_valid c%0d", c), 32'(rsp_valid), 32'b0100);
            check($sformatf("bp rsp_data c%0d", c), rsp_data, 32'd14);
            check($sformatf("bp req_ready c%0d", c), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = '0;
        #1 check("bp next grant", 32'(req_ready), 32'b1000);

        // Reset while requester 3's operation is in EXEC.
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("midreset req_ready", 32'(req_ready), 32'd0);
        check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset rsp_data", rsp_data, 32'd0);
        check("midreset rsp_zero", 32'(rsp_zero), 32'd0);
        check("midreset rsp_of", 32'(rsp_of), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '1;
        #1 check("post reset grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("post reset rsp_valid", 32'(rsp_valid), 32'b0001);
        check("post reset rsp_data", rsp_data, 32'd10);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
        check("post reset released", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
